// File: rtl/seq_lib_pkg.sv
// Shared definitions for the sequential-circuits library: mode encodings for shift registers.
package seq_lib_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'd6;

endpackage

// File: rtl/preset_shift_reg_if.sv
// Control and data bundle of preset_shift_reg; master drives controls, slave is the register.
interface preset_shift_reg_if #(
    parameter int unsigned WIDTH = 8
);
    import seq_lib_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic              clr;
    logic              pr;
    logic              en;
    logic [MODE_W-1:0] mode;
    logic [WIDTH-1:0]  d;
    logic              sin_l;
    logic              sin_r;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  qb;
    logic              sout_msb;
    logic              sout_lsb;
    logic [CW-1:0]     cnt;
    logic              done;

    modport master (
        output clr, pr, en, mode, d, sin_l, sin_r,
        input  q, qb, sout_msb, sout_lsb, cnt, done
    );

    modport slave (
        input  clr, pr, en, mode, d, sin_l, sin_r,
        output q, qb, sout_msb, sout_lsb, cnt, done
    );

endinterface

// File: rtl/sat_shift_cnt.sv
// Saturating shift counter with a registered one-cycle pulse on reaching MAX.
module sat_shift_cnt #(
    parameter int unsigned  MAX = 8,
    localparam int unsigned CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          done
);

    localparam logic [CW-1:0] MaxCw = CW'(MAX);

    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_done_nxt;

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_done_nxt = 1'b0;
        if (clear) begin
            w_cnt_nxt = '0;
        end else if (inc && (r_cnt != MaxCw)) begin
            w_cnt_nxt = r_cnt + CW'(1);
            // Pulse only on the WIDTH-1 -> WIDTH step, never while saturated.
            w_done_nxt = (r_cnt == MaxCw - CW'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign cnt  = r_cnt;
    assign done = r_done;

endmodule

// File: rtl/preset_shift_reg.sv
// Register with sync clear/preset, enable, and load/shift/rotate/arith-shift modes.
module preset_shift_reg
    import seq_lib_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input logic               clk,
    input logic               rst,
    preset_shift_reg_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_clear;
    logic             w_inc;
    logic [CW-1:0]    w_cnt;
    logic             w_done;

    // Priority: clr > pr > !en > mode.
    always_comb begin
        w_q_nxt = r_q;
        w_clear = 1'b0;
        w_inc   = 1'b0;
        if (bus.clr) begin
            w_q_nxt = '0;
            w_clear = 1'b1;
        end else if (bus.pr) begin
            w_q_nxt = PRESET_VAL;
            w_clear = 1'b1;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_HOLD: w_q_nxt = r_q;
                MODE_LOAD: begin
                    w_q_nxt = bus.d;
                    w_clear = 1'b1;
                end
                MODE_SHL: begin
                    w_q_nxt = {r_q[WIDTH-2:0], bus.sin_l};
                    w_inc   = 1'b1;
                end
                MODE_SHR: begin
                    w_q_nxt = {bus.sin_r, r_q[WIDTH-1:1]};
                    w_inc   = 1'b1;
                end
                MODE_ROL: begin
                    w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_inc   = 1'b1;
                end
                MODE_ROR: begin
                    w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
                    w_inc   = 1'b1;
                end
                MODE_ASR: begin
                    w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                    w_inc   = 1'b1;
                end
                default: w_q_nxt = r_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    sat_shift_cnt #(
        .MAX (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .inc   (w_inc),
        .cnt   (w_cnt),
        .done  (w_done)
    );

    assign bus.q        = r_q;
    assign bus.qb       = ~r_q;
    assign bus.sout_msb = r_q[WIDTH-1];
    assign bus.sout_lsb = r_q[0];
    assign bus.cnt      = w_cnt;
    assign bus.done     = w_done;

endmodule

// File: tb/tb_preset_shift_reg.sv
// Directed self-checking bench for preset_shift_reg (WIDTH=8).
module tb_preset_shift_reg;
    import seq_lib_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    preset_shift_reg_if #(.WIDTH(8)) bus ();

    preset_shift_reg #(
        .WIDTH      (8),
        .RESET_VAL  (8'h00),
        .PRESET_VAL (8'hFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic p, input logic e, input logic [2:0] m,
                         input logic [7:0] dv);
        bus.clr  = c;
        bus.pr   = p;
        bus.en   = e;
        bus.mode = m;
        bus.d    = dv;
    endtask

    initial begin
        logic [7:0] pat;
        int         pulses;
        checks   = 0;
        failures = 0;
        rst       = 1'b1;
        drive(1'b0, 1'b0, 1'b0, MODE_HOLD, 8'h00);
        bus.sin_l = 1'b0;
        bus.sin_r = 1'b0;
        tick();
        tick();
        chk("reset_q", bus.q, 8'h00);
        chk("reset_qb", bus.qb, 8'hFF);
        chk("reset_cnt", bus.cnt, 0);
        chk("reset_done", bus.done, 0);
        rst = 1'b0;

        // Async reset mid-cycle while q=5A
        drive(1'b0, 1'b0, 1'b1, MODE_LOAD, 8'h5A);
        tick();
        chk("load_5a", bus.q, 8'h5A);
        chk("load_5a_lsb", bus.sout_lsb, 0);
        drive(1'b0, 1'b0, 1'b0, MODE_HOLD, 8'h00);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q", bus.q, 8'h00);
        chk("async_rst_qb", bus.qb, 8'hFF);
        chk("async_rst_cnt", bus.cnt, 0);
        #1 rst = 1'b0;
        tick();

        // Preset vs clear
        drive(1'b0, 1'b1, 1'b0, MODE_HOLD, 8'h00);
        tick();
        chk("preset_en0", bus.q, 8'hFF);
        drive(1'b1, 1'b1, 1'b1, MODE_HOLD, 8'h00);
        tick();
        chk("clr_beats_pr", bus.q, 8'h00);
        drive(1'b0, 1'b1, 1'b1, MODE_LOAD, 8'h3C);
        tick();
        chk("pr_beats_load", bus.q, 8'hFF);

        // Serializer
        drive(1'b0, 1'b0, 1'b1, MODE_LOAD, 8'hA5);
        tick();
        chk("ser_load", bus.q, 8'hA5);
        chk("ser_load_cnt", bus.cnt, 0);
        pat = 8'hA5;
        bus.mode  = MODE_SHL;
        bus.sin_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ser_msb%0d", i), bus.sout_msb, pat[7-i]);
            tick();
            chk($sformatf("ser_cnt%0d", i), bus.cnt, i + 1);
            chk($sformatf("ser_done%0d", i), bus.done, (i == 7) ? 1 : 0);
        end
        chk("ser_final_q", bus.q, 8'h00);
        tick();
        chk("ser_sat_cnt", bus.cnt, 8);
        chk("ser_sat_done", bus.done, 0);

        // Rotate and arithmetic shift
        drive(1'b0, 1'b0, 1'b1, MODE_LOAD, 8'h81);
        tick();
        bus.mode = MODE_ROL;
        tick();
        chk("rol", bus.q, 8'h03);
        bus.mode = MODE_ROR;
        tick();
        chk("ror1", bus.q, 8'h81);
        tick();
        chk("ror2", bus.q, 8'hC0);
        chk("rot_cnt", bus.cnt, 3);
        drive(1'b0, 1'b0, 1'b1, MODE_LOAD, 8'h80);
        tick();
        bus.mode  = MODE_ASR;
        bus.sin_r = 1'b0;
        tick();
        tick();
        tick();
        chk("asr3", bus.q, 8'hF0);

        // Enable and reserved/hold modes with a non-zero count
        drive(1'b0, 1'b0, 1'b1, MODE_LOAD, 8'h3C);
        tick();
        bus.mode = MODE_ROL;
        tick();
        chk("en_rol", bus.q, 8'h78);
        bus.mode = MODE_ROR;
        tick();
        drive(1'b0, 1'b0, 1'b0, MODE_SHL, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        chk("en0_q", bus.q, 8'h3C);
        chk("en0_cnt", bus.cnt, 2);
        bus.en   = 1'b1;
        bus.mode = 3'd7;
        tick();
        chk("mode7_q", bus.q, 8'h3C);
        chk("mode7_cnt", bus.cnt, 2);
        bus.mode = MODE_HOLD;
        tick();
        chk("hold_q", bus.q, 8'h3C);

        // Reset mid-count
        drive(1'b0, 1'b0, 1'b1, MODE_LOAD, 8'hFF);
        tick();
        bus.mode  = MODE_SHR;
        bus.sin_r = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_cnt7", bus.cnt, 7);
        chk("mid_q", bus.q, 8'h01);
        rst = 1'b1;
        #1;
        chk("mid_rst_cnt", bus.cnt, 0);
        chk("mid_rst_q", bus.q, 8'h00);
        tick();
        chk("mid_rst_done", bus.done, 0);
        rst       = 1'b0;
        bus.sin_r = 1'b1;
        pulses    = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done === 1'b1) pulses++;
            chk($sformatf("rs_done%0d", i), bus.done, (i == 7) ? 1 : 0);
        end
        chk("rs_q", bus.q, 8'hFF);
        tick();
        if (bus.done === 1'b1) pulses++;
        chk("rs_pulses", pulses, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/preset_shift_reg.md
Name: preset_shift_reg

Overview:
- Parametrised register with synchronous clear and preset, clock enable, and mode-selected parallel load, shift, rotate or arithmetic shift.
- Includes a saturating shift counter and a one-cycle `done` pulse, so it can act as a serializer or deserializer.
- General-purpose storage and serial-conversion primitive in the sequential-circuits library.
- Asynchronous reset takes priority over the synchronous clear and preset.

Parameters:
- WIDTH, 8: register width in bits, ≥ 2.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into `q` on `rst`.
- PRESET_VAL, {WIDTH{1'b1}}: value loaded into `q` on `pr`.
- CW, $clog2(WIDTH+1): counter width (derived localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- clr  in  1  synchronous clear, active-high.
- pr  in  1  synchronous preset, active-high.
- en  in  1  clock enable for mode operations.
- mode  in  3  operation select (see Behaviour).
- d  in  WIDTH  parallel load data.
- sin_l  in  1  serial input entering at the LSB on a left shift.
- sin_r  in  1  serial input entering at the MSB on a right shift.
- q  out  WIDTH  register contents.
- qb  out  WIDTH  ~q, combinational.
- sout_msb  out  1  q[WIDTH-1], combinational.
- sout_lsb  out  1  q[0], combinational.
- cnt  out  CW  shifts since last load, clear or preset; saturates at WIDTH.
- done  out  1  registered one-cycle pulse.

Behaviour:
- Reset is asynchronous, active-high, on clock clk. While `rst` is high: q=RESET_VAL, cnt=0, done=0.
- Priority on each rising clock edge, highest first: clr > pr > !en > mode.
  - clr: q=0, cnt=0, done=0. Applies regardless of `en`.
  - pr (clr low): q=PRESET_VAL, cnt=0, done=0. Applies regardless of `en`.
  - en=0: q and cnt hold; done=0.
- Mode encoding, applied only when en=1 and clr=pr=0:
  - 0 HOLD: q unchanged.
  - 1 LOAD: q=d; cnt=0.
  - 2 SHL: q={q[WIDTH-2:0], sin_l}.
  - 3 SHR: q={sin_r, q[WIDTH-1:1]}.
  - 4 ROL: q={q[WIDTH-2:0], q[WIDTH-1]}.
  - 5 ROR: q={q[0], q[WIDTH-1:1]}.
  - 6 ASR: q={q[WIDTH-1], q[WIDTH-1:1]}; sin_r ignored.
  - 7 reserved: behaves as HOLD. Not an error.
- Counter:
  - Modes 2–6 increment `cnt` by 1, saturating at WIDTH.
  - At saturation, further shifts still move `q`; `cnt` stays at WIDTH.
  - HOLD and mode 7 leave `cnt` unchanged.
- done:
  - Asserted for exactly the cycle after the edge on which `cnt` goes WIDTH-1 → WIDTH.
  - Otherwise 0; no repeat pulse while saturated.
  - Clear, preset, LOAD or `rst` in the pulse cycle kill the pulse at that edge.
- Latency: every registered effect is visible one cycle after the sampling edge. `qb`, `sout_msb` and `sout_lsb` track `q` in the same cycle.
- Simultaneous events:
  - clr and pr both high: clear wins.
  - pr and LOAD together: preset wins, `d` ignored.
  - rst asserted mid-shift: immediate RESET_VAL and cnt=0, no pulse. Operation resumes on the first edge after deassertion.
- All arithmetic is unsigned in CW bits. Counter compare uses WIDTH cast to CW bits.

Decomposition:
- Shared package `seq_lib_pkg`:
  - localparams MODE_HOLD=0, MODE_LOAD=1, MODE_SHL=2, MODE_SHR=3, MODE_ROL=4, MODE_ROR=5, MODE_ASR=6.
  - MODE_W=3.
- Sub-module `sat_shift_cnt` (parameter MAX=WIDTH):
  - Inputs: clk, rst, clear, inc.
  - Outputs: cnt, done.
  - Holds the saturating counter and the done pulse.
- The top level holds the data path and priority decode.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'h00, `rst` pulsed asynchronously mid-cycle while q=8'h5A. Required: q=8'h00, qb=8'hFF, cnt=0 before the next edge.
- Preset vs clear: pr=1 with en=0 → q=8'hFF next cycle. Then clr=pr=1 → q=8'h00. Then pr=1 with mode=LOAD, d=8'h3C → q=8'hFF.
- Serializer:
  - LOAD d=8'hA5, then 8 SHL cycles with sin_l=0.
  - sout_msb sequence before each shift edge: 1,0,1,0,0,1,0,1.
  - cnt counts 1..8; done=1 exactly the cycle after the 8th shift; final q=8'h00.
  - A 9th shift leaves cnt=8 and done=0.
- Rotate and arithmetic shift:
  - LOAD 8'h81, ROL → 8'h03; ROR → 8'h81; ROR → 8'hC0.
  - LOAD 8'h80, three ASR with sin_r=0 → 8'hF0.
- Enable and reserved mode: q=8'h3C, en=0 with mode=SHL for 5 cycles → q=8'h3C, cnt unchanged. mode=7 with en=1 → q unchanged.
- Reset mid-count: after 7 SHR cycles, assert `rst` → cnt=0, done never pulses. Deassert `rst`, then 8 SHR cycles → single done pulse.
